handshake_ram: RTL and testbench
================================

HANDSHAKE_RAM -- requirements
Module: handshake_ram

Interface
REQ-001 Parameter ADDR_W, default 8, byte-address width; memory depth SHALL be 2**ADDR_W bytes.
REQ-002 Parameter WAIT_CYCLES, default 2, number of idle cycles between request acceptance and each MOC pulse; 0 is legal.
REQ-003 Parameter ALIGN_CHECK, default 1, enables the misalignment error; 0 means misaligned accesses are performed using the unaligned byte addresses.
REQ-004 Clk  input  1  sole clock; all state SHALL update on the rising edge.
REQ-005 clr  input  1  asynchronous, active-high reset.
REQ-006 Enable  input  1  chip enable; requests are ignored while low.
REQ-007 MOV  input  1  memory operation valid, held high by the master until MOC is seen.
REQ-008 R_W  input  1  1 = read, 0 = write.
REQ-009 Type  input  2  00 byte, 01 halfword, 10 word, 11 doubleword.
REQ-010 Address  input  ADDR_W  byte address of the first byte.
REQ-011 DataIn  input  32  write data, right-justified for byte and halfword accesses.
REQ-012 DataOut  output  32  read data, registered.
REQ-013 MOC  output  1  memory operation complete, one-cycle pulse per beat.
REQ-014 Busy  output  1  high in every state except IDLE.
REQ-015 Err  output  1  misalignment flag, valid while MOC=1.

Function
REQ-016 Storage SHALL be byte-organised and big-endian: the byte at Address maps to DataOut[31:24] of a word.
REQ-017 The FSM SHALL have exactly these states: IDLE, WAIT, ACK, DONE.
REQ-018 In IDLE, when Enable=1 and MOV=1 are sampled, the block SHALL latch Address, Type, R_W and DataIn, load the wait counter with WAIT_CYCLES, and go to WAIT.
REQ-019 In WAIT, the counter SHALL decrement each cycle; on the cycle it is 0 the FSM SHALL go to ACK. With WAIT_CYCLES=0, WAIT therefore lasts one cycle.
REQ-020 MOC SHALL be high for exactly the one cycle spent in ACK; latency from the accepting edge to MOC=1 is WAIT_CYCLES+1 cycles.
REQ-021 Read data SHALL be loaded into DataOut on the edge entering ACK, and DataOut SHALL hold until the next beat's ACK or a reset.
REQ-022 A byte read SHALL zero-extend into DataOut[7:0], a halfword read into DataOut[15:0] (big-endian), and a word read SHALL fill DataOut[31:0].
REQ-023 Writes SHALL commit on the edge leaving ACK; a byte write stores DataIn[7:0], a halfword write stores DataIn[15:0], and a word write stores DataIn[31:0]; no other bytes change.
REQ-024 A doubleword access SHALL be two word beats: after the first ACK the FSM returns to WAIT with address+4 (modulo 2**ADDR_W) and the counter reloaded, then produces a second ACK.
REQ-025 A doubleword write SHALL store the latched DataIn on beat 1 and the DataIn value sampled in the first ACK cycle on beat 2.
REQ-026 After the final ACK the FSM SHALL go to DONE and remain there until MOV=0 is sampled, then return to IDLE; a request is never accepted in DONE.
REQ-027 With ALIGN_CHECK=1, an access is misaligned when halfword has Address[0]=1, or word/doubleword has Address[1:0]!=0; misaligned accesses SHALL go straight to ACK after the wait, pulse MOC with Err=1, perform no write, set DataOut=0, and skip the second doubleword beat.
REQ-028 Err SHALL be 0 whenever MOC=0.
REQ-029 Multi-byte accesses whose bytes exceed the top address SHALL wrap modulo 2**ADDR_W.
REQ-030 Enable or MOV falling after acceptance SHALL NOT abort the operation.

Reset
REQ-031 While clr=1, regardless of Clk: state=IDLE, MOC=0, Err=0, Busy=0, DataOut=0, counter=0.
REQ-032 Reset SHALL NOT clear memory contents; a write whose ACK edge had not occurred SHALL NOT be committed.
REQ-033 After clr deasserts, the first request SHALL be accepted on the first edge with Enable=MOV=1.

Verification
REQ-034 With WAIT_CYCLES=2: write word 0xDEADBEEF to 0x10, then read word at 0x10 -> MOC at accept+3, DataOut=0xDEADBEEF, Err=0.
REQ-035 Byte write 0x5A to 0x11 after REQ-034, then word read at 0x10 -> 0xDE5ABEEF; halfword read at 0x12 -> 0x0000BEEF.
REQ-036 Doubleword write 0x11111111 and 0x22222222 at 0xFC with ADDR_W=8 -> two MOC pulses; word reads at 0xFC and 0x00 return 0x11111111 and 0x22222222, respectively.
REQ-037 Word read at 0x13 with ALIGN_CHECK=1 -> one MOC pulse with Err=1, DataOut=0, and memory unchanged.
REQ-038 Assert clr during WAIT of a word write to 0x20 -> MOC never pulses, Busy=0 immediately, and a later read at 0x20 returns the old value.
REQ-039 Hold MOV high for 5 cycles after MOC -> FSM stays in DONE with no second access, and a new request is accepted only after MOV=0 for one cycle; also repeat REQ-034 with WAIT_CYCLES=0 -> MOC at accept+1.

Source files
------------

// File: rtl/handshake_ram.sv
// Byte-organised, big-endian RAM behind a MOV/MOC handshake with a programmable
// wait before each completion pulse; doublewords run as two word beats.
module handshake_ram #(
  parameter int ADDR_W      = 8,
  parameter int WAIT_CYCLES = 2,
  parameter int ALIGN_CHECK = 1
) (
  input  logic              Clk,
  input  logic              clr,
  input  logic              Enable,
  input  logic              MOV,
  input  logic              R_W,
  input  logic [1:0]        Type,
  input  logic [ADDR_W-1:0] Address,
  input  logic [31:0]       DataIn,
  output logic [31:0]       DataOut,
  output logic              MOC,
  output logic              Busy,
  output logic              Err
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int CNT_W = (WAIT_CYCLES < 1) ? 1 : $clog2(WAIT_CYCLES + 1);
  localparam logic [CNT_W-1:0] WAIT_LD = CNT_W'(WAIT_CYCLES);

  localparam logic [1:0] T_BYTE = 2'b00;
  localparam logic [1:0] T_HALF = 2'b01;
  localparam logic [1:0] T_DW   = 2'b11;

  typedef enum logic [1:0] {IDLE, WAIT, ACK, DONE} state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt_q;
  logic              beat2_q;

  logic [7:0]        mem [0:DEPTH-1];

  logic [ADDR_W-1:0] addr_p0;
  logic [1:0]        type_p0;
  logic              rw_p0;
  logic [31:0]       data_p0;
  logic              misalign_p0;

  logic [ADDR_W-1:0] a0, a1, a2, a3;
  logic [31:0]       rd_word;
  logic              accept;
  logic              next_beat;

  function automatic logic misaligned(input logic [ADDR_W-1:0] addr,
                                      input logic [1:0]        typ);
    logic m;
    m = 1'b0;
    if (ALIGN_CHECK != 0) begin
      case (typ)
        T_HALF:  m = addr[0];
        T_BYTE:  m = 1'b0;
        default: m = (addr[1:0] != 2'b00);
      endcase
    end
    return m;
  endfunction

  assign accept    = (state == IDLE) && Enable && MOV;
  assign next_beat = (state == ACK) && (type_p0 == T_DW) && !beat2_q && !misalign_p0;

  // Byte lanes wrap naturally at the top of the address space
  assign a0 = addr_p0;
  assign a1 = addr_p0 + ADDR_W'(1);
  assign a2 = addr_p0 + ADDR_W'(2);
  assign a3 = addr_p0 + ADDR_W'(3);

  always_comb begin
    rd_word = '0;
    case (type_p0)
      T_BYTE:  rd_word = {24'h0, mem[a0]};
      T_HALF:  rd_word = {16'h0, mem[a0], mem[a1]};
      default: rd_word = {mem[a0], mem[a1], mem[a2], mem[a3]};
    endcase
  end

  // Request capture; the second doubleword beat takes the next word address
  // and whatever DataIn the master presents during the first ACK.
  always_ff @(posedge Clk) begin
    if (accept) begin
      addr_p0     <= Address;
      type_p0     <= Type;
      rw_p0       <= R_W;
      data_p0     <= DataIn;
      misalign_p0 <= misaligned(Address, Type);
    end else if (next_beat) begin
      addr_p0 <= addr_p0 + ADDR_W'(4);
      data_p0 <= DataIn;
    end
  end

  // Writes commit on the edge leaving ACK, so a reset before then drops them
  always_ff @(posedge Clk) begin
    if ((state == ACK) && !rw_p0 && !misalign_p0) begin
      case (type_p0)
        T_BYTE: mem[a0] <= data_p0[7:0];
        T_HALF: begin
          mem[a0] <= data_p0[15:8];
          mem[a1] <= data_p0[7:0];
        end
        default: begin
          mem[a0] <= data_p0[31:24];
          mem[a1] <= data_p0[23:16];
          mem[a2] <= data_p0[15:8];
          mem[a3] <= data_p0[7:0];
        end
      endcase
    end
  end

  always_ff @(posedge Clk or posedge clr) begin
    if (clr) begin
      state   <= IDLE;
      cnt_q   <= '0;
      beat2_q <= 1'b0;
      MOC     <= 1'b0;
      Err     <= 1'b0;
      Busy    <= 1'b0;
      DataOut <= '0;
    end else begin
      MOC <= 1'b0;
      Err <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            state   <= WAIT;
            cnt_q   <= WAIT_LD;
            beat2_q <= 1'b0;
            Busy    <= 1'b1;
          end
        end
        WAIT: begin
          if (cnt_q == '0) begin
            state <= ACK;
            MOC   <= 1'b1;
            Err   <= misalign_p0;
            if (misalign_p0)
              DataOut <= '0;
            else if (rw_p0)
              DataOut <= rd_word;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        ACK: begin
          if (next_beat) begin
            state   <= WAIT;
            cnt_q   <= WAIT_LD;
            beat2_q <= 1'b1;
          end else begin
            state <= DONE;
          end
        end
        DONE: begin
          if (!MOV) begin
            state <= IDLE;
            Busy  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_handshake_ram.sv
// Randomised bench for handshake_ram: two instances (WAIT_CYCLES=2 and 0)
// share stimulus and are compared against a byte-array reference model.
module tb_handshake_ram;

  logic        Clk = 1'b0;
  logic        clr;
  logic        en0, en2;
  logic        MOV;
  logic        R_W;
  logic [1:0]  Type;
  logic [7:0]  Address;
  logic [31:0] DataIn;

  logic [31:0] dout0, dout2;
  logic        moc0, moc2, busy0, busy2, err0, err2;

  bit          sel;
  logic [31:0] dout_s;
  logic        moc_s, busy_s, err_s;

  int          n_chk = 0;
  int          n_err = 0;

  logic [7:0]  mm [2][256];
  logic [31:0] exp_do [2];

  always #5 Clk = ~Clk;

  handshake_ram #(.ADDR_W(8), .WAIT_CYCLES(2), .ALIGN_CHECK(1)) dut2 (
    .Clk(Clk), .clr(clr), .Enable(en2), .MOV(MOV), .R_W(R_W), .Type(Type),
    .Address(Address), .DataIn(DataIn), .DataOut(dout2), .MOC(moc2),
    .Busy(busy2), .Err(err2)
  );

  handshake_ram #(.ADDR_W(8), .WAIT_CYCLES(0), .ALIGN_CHECK(1)) dut0 (
    .Clk(Clk), .clr(clr), .Enable(en0), .MOV(MOV), .R_W(R_W), .Type(Type),
    .Address(Address), .DataIn(DataIn), .DataOut(dout0), .MOC(moc0),
    .Busy(busy0), .Err(err0)
  );

  assign dout_s = sel ? dout2 : dout0;
  assign moc_s  = sel ? moc2  : moc0;
  assign busy_s = sel ? busy2 : busy0;
  assign err_s  = sel ? err2  : err0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic bit misal(input logic [1:0] t, input logic [7:0] a);
    return (t == 2'd1 && (a % 2) != 0) || (t >= 2'd2 && (a % 4) != 0);
  endfunction

  function automatic int nbytes(input logic [1:0] t);
    return (t == 2'd0) ? 1 : (t == 2'd1) ? 2 : 4;
  endfunction

  function automatic logic [31:0] mread(input bit s, input logic [7:0] a, input logic [1:0] t);
    logic [31:0] r;
    r = 32'h0;
    for (int i = 0; i < nbytes(t); i++)
      r = (r << 8) | 32'(mm[s][(int'(a) + i) % 256]);
    return r;
  endfunction

  task automatic mwrite(input bit s, input logic [7:0] a, input logic [1:0] t, input logic [31:0] d);
    int n;
    n = nbytes(t);
    for (int i = 0; i < n; i++)
      mm[s][(int'(a) + i) % 256] = 8'(d >> (8 * (n - 1 - i)));
  endtask

  // One complete transaction; starts and ends at a falling edge with the DUT idle.
  task automatic access(input bit s, input bit rw, input logic [1:0] typ,
                        input logic [7:0] a, input logic [31:0] d1,
                        input logic [31:0] d2, input bit hold);
    int w, beats, cyc;
    bit mis, seen;
    logic [7:0] ab;
    w     = s ? 2 : 0;
    mis   = misal(typ, a);
    beats = (typ == 2'd3 && !mis) ? 2 : 1;
    sel = s; en2 = s; en0 = !s;
    MOV = 1'b1; R_W = rw; Type = typ; Address = a; DataIn = d1;
    for (int b = 0; b < beats; b++) begin
      seen = 1'b0;
      cyc  = 0;
      while (!seen && cyc < 40) begin
        @(negedge Clk);
        cyc++;
        if (b == 0 && cyc == 1) begin
          chk("busy_wait", busy_s, 1'b1);
          en0 = 1'b0; en2 = 1'b0;
          Address = 8'($urandom); Type = 2'($urandom); R_W = 1'($urandom);
          DataIn = $urandom;
        end
        if (moc_s) seen = 1'b1;
        else chk("err_without_moc", err_s, 1'b0);
      end
      chk("moc_latency", cyc - 1, w + 1);
      if (!seen) begin
        MOV = 1'b0;
        repeat (3) @(negedge Clk);
        return;
      end
      ab = a + 8'(4 * b);
      chk("err_flag", err_s, mis);
      if (mis) exp_do[s] = 32'h0;
      else if (rw) exp_do[s] = mread(s, ab, (typ == 2'd3) ? 2'd2 : typ);
      chk("data_out", dout_s, exp_do[s]);
      if (!rw && !mis) mwrite(s, ab, (typ == 2'd3) ? 2'd2 : typ, (b == 0) ? d1 : d2);
      if (b == 0 && beats == 2) DataIn = d2;
    end
    if (hold) begin
      for (int i = 0; i < 5; i++) begin
        @(negedge Clk);
        chk("done_no_moc", moc_s, 1'b0);
        chk("done_busy", busy_s, 1'b1);
      end
      MOV = 1'b0;
      @(negedge Clk);
    end else begin
      MOV = 1'b0;
      @(negedge Clk);
      @(negedge Clk);
    end
    chk("idle_busy", busy_s, 1'b0);
  endtask

  initial begin
    clr = 1'b1; en0 = 1'b0; en2 = 1'b0; MOV = 1'b0; R_W = 1'b0;
    Type = 2'd0; Address = 8'h0; DataIn = 32'h0; sel = 1'b1;
    exp_do[0] = 32'h0; exp_do[1] = 32'h0;
    repeat (2) @(negedge Clk);
    chk("rst_dout", dout2, 32'h0);
    chk("rst_moc", moc2, 1'b0);
    chk("rst_busy", busy2, 1'b0);
    chk("rst_err", err2, 1'b0);
    clr = 1'b0;

    // Fill the WAIT_CYCLES=2 instance so every model byte is known
    for (int i = 0; i < 64; i++)
      access(1'b1, 1'b0, 2'd2, 8'(4 * i), $urandom, 32'h0, 1'b0);

    access(1'b1, 1'b0, 2'd2, 8'h10, 32'hDEADBEEF, 32'h0, 1'b0);
    access(1'b1, 1'b1, 2'd2, 8'h10, 32'h0, 32'h0, 1'b0);
    chk("word_rd_10", dout2, 32'hDEADBEEF);
    access(1'b1, 1'b0, 2'd0, 8'h11, 32'hFFFFFF5A, 32'h0, 1'b0);
    access(1'b1, 1'b1, 2'd2, 8'h10, 32'h0, 32'h0, 1'b0);
    chk("byte_merge", dout2, 32'hDE5ABEEF);
    access(1'b1, 1'b1, 2'd1, 8'h12, 32'h0, 32'h0, 1'b0);
    chk("half_rd_12", dout2, 32'h0000BEEF);

    access(1'b1, 1'b0, 2'd3, 8'hFC, 32'h11111111, 32'h22222222, 1'b0);
    access(1'b1, 1'b1, 2'd2, 8'hFC, 32'h0, 32'h0, 1'b0);
    chk("dw_lo", dout2, 32'h11111111);
    access(1'b1, 1'b1, 2'd2, 8'h00, 32'h0, 32'h0, 1'b0);
    chk("dw_wrap", dout2, 32'h22222222);

    access(1'b1, 1'b1, 2'd2, 8'h13, 32'h0, 32'h0, 1'b0);
    chk("misal_dout", dout2, 32'h0);
    access(1'b1, 1'b0, 2'd3, 8'h22, 32'hA5A5A5A5, 32'h5A5A5A5A, 1'b0);
    access(1'b1, 1'b1, 2'd2, 8'h20, 32'h0, 32'h0, 1'b0);
    access(1'b1, 1'b1, 2'd2, 8'h24, 32'h0, 32'h0, 1'b0);
    access(1'b1, 1'b1, 2'd2, 8'h10, 32'h0, 32'h0, 1'b0);
    chk("misal_no_write", dout2, 32'hDE5ABEEF);

    // Reset in the middle of a write's wait phase
    sel = 1'b1; en2 = 1'b1; MOV = 1'b1; R_W = 1'b0; Type = 2'd2;
    Address = 8'h20; DataIn = 32'hCAFEF00D;
    @(negedge Clk);
    en2 = 1'b0; MOV = 1'b0;
    clr = 1'b1;
    #1;
    chk("clr_busy", busy2, 1'b0);
    chk("clr_moc", moc2, 1'b0);
    chk("clr_dout", dout2, 32'h0);
    exp_do[0] = 32'h0; exp_do[1] = 32'h0;
    for (int i = 0; i < 4; i++) begin
      @(negedge Clk);
      chk("clr_hold_moc", moc2, 1'b0);
    end
    clr = 1'b0;
    access(1'b1, 1'b1, 2'd2, 8'h20, 32'h0, 32'h0, 1'b0);

    access(1'b1, 1'b1, 2'd2, 8'h10, 32'h0, 32'h0, 1'b1);
    access(1'b1, 1'b0, 2'd3, 8'h40, $urandom, $urandom, 1'b1);
    access(1'b1, 1'b1, 2'd3, 8'h40, 32'h0, 32'h0, 1'b0);

    for (int i = 0; i < 150; i++)
      access(1'b1, 1'($urandom), 2'($urandom), 8'($urandom), $urandom, $urandom,
             $urandom_range(0, 9) == 0);

    // Zero-wait instance: only addresses written first are read back
    access(1'b0, 1'b0, 2'd2, 8'h10, 32'hDEADBEEF, 32'h0, 1'b0);
    access(1'b0, 1'b1, 2'd2, 8'h10, 32'h0, 32'h0, 1'b0);
    chk("w0_word_rd", dout0, 32'hDEADBEEF);
    access(1'b0, 1'b0, 2'd0, 8'h11, 32'h0000005A, 32'h0, 1'b1);
    access(1'b0, 1'b1, 2'd1, 8'h10, 32'h0, 32'h0, 1'b0);
    chk("w0_half_rd", dout0, 32'h0000DE5A);
    access(1'b0, 1'b0, 2'd3, 8'hFC, 32'h11111111, 32'h22222222, 1'b0);
    access(1'b0, 1'b1, 2'd3, 8'hFC, 32'h0, 32'h0, 1'b0);
    chk("w0_dw_rd", dout0, 32'h22222222);
    access(1'b0, 1'b1, 2'd1, 8'h11, 32'h0, 32'h0, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
